// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter: round-robin arbiter that grants one of four requesters
// ownership of a shared 16-bit bus for at most MAX_HOLD cycles. After each
// release there is a one-cycle break-before-make GAP. Data is gated onto the
// bus by ANDing each source with its grant bit.
module bus_gate_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  REQ,
  input  logic [15:0] DIN0,
  input  logic [15:0] DIN1,
  input  logic [15:0] DIN2,
  input  logic [15:0] DIN3,
  input  logic        BUS_READY,
  output logic [3:0]  GNT,
  output logic [15:0] BUS_DATA,
  output logic        BUS_VALID,
  output logic [1:0]  OWNER
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t        state;
  logic [1:0]    last;
  logic [CW-1:0] hold_cnt;

  logic [1:0]    pick;
  logic          pick_ok;
  logic [1:0]    idx;
  logic [15:0]   gated;
  logic          owner_req;

  // Round-robin pick: first set REQ bit searching upward from last+1, wrapping.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!pick_ok && REQ[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  // Gated bus word: each source masked by its own grant bit, then ORed.
  always_comb begin
    gated = ({16{GNT[0]}} & DIN0) | ({16{GNT[1]}} & DIN1) |
            ({16{GNT[2]}} & DIN2) | ({16{GNT[3]}} & DIN3);
    owner_req = REQ[OWNER];
  end

  // Arbitration FSM with registered grant, ownership and bus outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      GNT       <= '0;
      BUS_DATA  <= '0;
      BUS_VALID <= 1'b0;
      OWNER     <= '0;
      last      <= 2'd3;
      hold_cnt  <= '0;
    end else begin
      BUS_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_ok) begin
            GNT      <= 4'b0001 << pick;
            OWNER    <= pick;
            last     <= pick;
            hold_cnt <= '0;
            state    <= OWN;
          end else begin
            GNT <= '0;
          end
        end
        OWN: begin
          if (owner_req && BUS_READY) begin
            BUS_DATA  <= gated;
            BUS_VALID <= 1'b1;
          end
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
          // The word on the timeout cycle is still transferred above.
          if (!owner_req || hold_cnt == HOLD_LAST) begin
            GNT   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          GNT   <= '0;
          state <= IDLE;
        end
        default: begin
          GNT   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed self-checking bench for bus_gate_arbiter with MAX_HOLD=8.
module tb_bus_gate_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ;
  logic [15:0] DIN0, DIN1, DIN2, DIN3;
  logic        BUS_READY;
  logic [3:0]  GNT;
  logic [15:0] BUS_DATA;
  logic        BUS_VALID;
  logic [1:0]  OWNER;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [3:0]  prev_gnt = '0;

  bus_gate_arbiter #(.MAX_HOLD(8)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .DIN0(DIN0), .DIN1(DIN1), .DIN2(DIN2), .DIN3(DIN3),
    .BUS_READY(BUS_READY), .GNT(GNT), .BUS_DATA(BUS_DATA),
    .BUS_VALID(BUS_VALID), .OWNER(OWNER)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge, then sample on the falling edge and check invariants.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    check("onehot", 32'($countones(GNT) <= 1), 32'd1);
    check("valid_needs_prev_gnt", 32'(BUS_VALID && prev_gnt == 4'b0000), 32'd0);
    prev_gnt = GNT;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic v,
                            input logic [15:0] d);
    check({tag, "_gnt"}, 32'(GNT), 32'(g));
    check({tag, "_valid"}, 32'(BUS_VALID), 32'(v));
    check({tag, "_data"}, 32'(BUS_DATA), 32'(d));
  endtask

  initial begin
    RST = 1'b1; REQ = 4'b0000; BUS_READY = 1'b1;
    DIN0 = 16'hAAAA; DIN1 = 16'h1111; DIN2 = 16'h5555; DIN3 = 16'h3C3C;
    @(negedge CLK);
    tick();
    tick();
    expect_out("reset", 4'b0000, 1'b0, 16'h0000);
    check("reset_owner", 32'(OWNER), 32'd0);

    // Requesters 0 and 2; requester 0 wins first after reset.
    RST = 1'b0; REQ = 4'b0101;
    tick();
    expect_out("grant0", 4'b0001, 1'b0, 16'h0000);
    check("grant0_owner", 32'(OWNER), 32'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      expect_out("own0", 4'b0001, 1'b1, 16'hAAAA);
    end
    tick();
    expect_out("timeout0", 4'b0000, 1'b1, 16'hAAAA);
    tick();
    expect_out("gap0", 4'b0000, 1'b0, 16'hAAAA);
    tick();
    expect_out("grant2", 4'b0100, 1'b0, 16'hAAAA);
    check("grant2_owner", 32'(OWNER), 32'd2);
    tick();
    expect_out("xfer2", 4'b0100, 1'b1, 16'h5555);

    // Owner drops request: release without transfer, then idle.
    REQ = 4'b0000;
    tick();
    expect_out("release2", 4'b0000, 1'b0, 16'h5555);
    tick();
    expect_out("gap2", 4'b0000, 1'b0, 16'h5555);
    tick();
    expect_out("idle", 4'b0000, 1'b0, 16'h5555);

    // Lone requester 3 is re-granted after its own timeout.
    REQ = 4'b1000;
    tick();
    expect_out("grant3", 4'b1000, 1'b0, 16'h5555);
    for (int i = 0; i < 7; i++) tick();
    expect_out("own3_end", 4'b1000, 1'b1, 16'h3C3C);
    tick();
    expect_out("timeout3", 4'b0000, 1'b1, 16'h3C3C);
    tick();
    expect_out("gap3", 4'b0000, 1'b0, 16'h3C3C);
    tick();
    expect_out("regrant3", 4'b1000, 1'b0, 16'h3C3C);
    check("regrant3_owner", 32'(OWNER), 32'd3);

    // Requester 0 joins; after 3's timeout the search wraps to 0.
    REQ = 4'b1001;
    for (int i = 0; i < 7; i++) tick();
    check("hold3_gnt", 32'(GNT), 32'(4'b1000));
    tick();
    check("timeout3b_gnt", 32'(GNT), 32'd0);
    tick();
    tick();
    expect_out("wrap0", 4'b0001, 1'b0, 16'h3C3C);

    // Stall three cycles: no transfer, timeout still counts from the grant.
    BUS_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("stall", 4'b0001, 1'b0, 16'h3C3C);
    end
    BUS_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("unstall", 4'b0001, 1'b1, 16'hAAAA);
    end
    tick();
    expect_out("stall_timeout", 4'b0000, 1'b1, 16'hAAAA);

    // Non-owner change during GAP only matters once back in IDLE.
    REQ = 4'b0010;
    tick();
    expect_out("gap_ignore", 4'b0000, 1'b0, 16'hAAAA);
    tick();
    expect_out("grant1", 4'b0010, 1'b0, 16'hAAAA);
    tick();
    expect_out("xfer1", 4'b0010, 1'b1, 16'h1111);

    // Reset mid-ownership with all requesting: drop at once, then 0 first.
    RST = 1'b1; REQ = 4'b1111;
    tick();
    expect_out("rst_mid", 4'b0000, 1'b0, 16'h0000);
    check("rst_mid_owner", 32'(OWNER), 32'd0);
    tick();
    expect_out("rst_hold", 4'b0000, 1'b0, 16'h0000);
    RST = 1'b0;
    tick();
    expect_out("post_rst", 4'b0001, 1'b0, 16'h0000);
    tick();
    expect_out("post_rst_xfer", 4'b0001, 1'b1, 16'hAAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
